// File: rtl/multi_port_table_pkg.sv
// Shared types and helpers for the multi-port register table and its clear sweep.
package table_pkg;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_e;

  // Index width for a table of `size` entries; never narrower than one bit.
  function automatic int idx_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/multi_port_table_clear_ctrl.sv
// Background invalidate sweep: walks every entry once, one per cycle, after clr_start.
module table_clear_ctrl
  import table_pkg::*;
#(
  parameter int TABLE_SIZE = 32,
  localparam int IDX_W = idx_w(TABLE_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_start,
  output logic             clr_busy,
  output logic             clr_en,
  output logic [IDX_W-1:0] clr_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_SIZE - 1);

  clr_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLR_IDLE: begin
        // A new request is only honoured between sweeps.
        if (clr_start) begin
          state_d = CLR_SWEEP;
          ptr_d   = '0;
        end
      end
      CLR_SWEEP: begin
        if (ptr_q == LAST_IDX) begin
          state_d = CLR_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = CLR_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLR_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign clr_busy = (state_q == CLR_SWEEP);
  assign clr_en   = (state_q == CLR_SWEEP);
  assign clr_idx  = ptr_q;

endmodule

// File: rtl/multi_port_table.sv
// Multi-port register table: per-port read/write enables, valid bits, hit flags,
// write-collision flag and a non-stalling background invalidate sweep.
module multi_port_table
  import table_pkg::*;
#(
  parameter int TABLE_SIZE = 32,
  parameter int DATA_WIDTH = 8,
  parameter int WR_PORTS   = 2,
  parameter int RD_PORTS   = 2,
  parameter int RD_BYPASS  = 1,
  localparam int IDX_W = idx_w(TABLE_SIZE)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WR_PORTS-1:0]            wr_en,
  input  logic [WR_PORTS*IDX_W-1:0]      index_wr,
  input  logic [WR_PORTS*DATA_WIDTH-1:0] data_wr,
  input  logic [RD_PORTS-1:0]            rd_en,
  input  logic [RD_PORTS*IDX_W-1:0]      index_rd,
  output logic [RD_PORTS*DATA_WIDTH-1:0] data_rd,
  output logic [RD_PORTS-1:0]            rd_valid,
  output logic [RD_PORTS-1:0]            rd_hit,
  output logic                           wr_conflict,
  input  logic                           clr_start,
  output logic                           clr_busy
);

  logic [DATA_WIDTH-1:0] mem_q [TABLE_SIZE];
  logic [DATA_WIDTH-1:0] mem_d [TABLE_SIZE];
  logic [TABLE_SIZE-1:0] valid_q, valid_d;

  logic [TABLE_SIZE-1:0] ent_we;
  logic [DATA_WIDTH-1:0] ent_wdata [TABLE_SIZE];

  logic [DATA_WIDTH-1:0] rd_src_data [TABLE_SIZE];
  logic [TABLE_SIZE-1:0] rd_src_valid;

  logic [RD_PORTS*DATA_WIDTH-1:0] data_rd_q, data_rd_d;
  logic [RD_PORTS-1:0]            rd_valid_q, rd_valid_d;
  logic [RD_PORTS-1:0]            rd_hit_q, rd_hit_d;
  logic                           wr_conflict_q, wr_conflict_d;

  logic             clr_en;
  logic [IDX_W-1:0] clr_idx;

  // Non-power-of-two tables leave part of the index space unmapped.
  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < (IDX_W + 1)'(TABLE_SIZE);
  endfunction

  table_clear_ctrl #(
    .TABLE_SIZE (TABLE_SIZE)
  ) u_clear_ctrl (
    .clk       (clk),
    .rst       (rst),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_en    (clr_en),
    .clr_idx   (clr_idx)
  );

  // Later ports overwrite earlier ones, so the highest enabled port wins an entry.
  always_comb begin
    for (int e = 0; e < TABLE_SIZE; e++) begin
      ent_we[e]    = 1'b0;
      ent_wdata[e] = '0;
      for (int p = 0; p < WR_PORTS; p++) begin
        if (wr_en[p] && (index_wr[p*IDX_W +: IDX_W] == IDX_W'(e))) begin
          ent_we[e]    = 1'b1;
          ent_wdata[e] = data_wr[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // A write landing on the entry being swept in the same cycle keeps it valid.
  always_comb begin
    for (int e = 0; e < TABLE_SIZE; e++) begin
      mem_d[e]   = ent_we[e] ? ent_wdata[e] : mem_q[e];
      valid_d[e] = valid_q[e];
      if (clr_en && (clr_idx == IDX_W'(e))) begin
        valid_d[e] = 1'b0;
      end
      if (ent_we[e]) begin
        valid_d[e] = 1'b1;
      end
    end
  end

  always_comb begin
    wr_conflict_d = 1'b0;
    for (int p = 0; p < WR_PORTS; p++) begin
      for (int q = p + 1; q < WR_PORTS; q++) begin
        if (wr_en[p] && wr_en[q] &&
            (index_wr[p*IDX_W +: IDX_W] == index_wr[q*IDX_W +: IDX_W]) &&
            in_range(index_wr[p*IDX_W +: IDX_W])) begin
          wr_conflict_d = 1'b1;
        end
      end
    end
  end

  generate
    if (RD_BYPASS != 0) begin : g_bypass
      always_comb begin
        for (int e = 0; e < TABLE_SIZE; e++) begin
          rd_src_data[e] = mem_d[e];
        end
        rd_src_valid = valid_d;
      end
    end else begin : g_no_bypass
      always_comb begin
        for (int e = 0; e < TABLE_SIZE; e++) begin
          rd_src_data[e] = mem_q[e];
        end
        rd_src_valid = valid_q;
      end
    end
  endgenerate

  // Idle read ports hold their last data and hit flag.
  always_comb begin
    data_rd_d  = data_rd_q;
    rd_hit_d   = rd_hit_q;
    rd_valid_d = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      if (rd_en[p]) begin
        rd_valid_d[p] = 1'b1;
        if (in_range(index_rd[p*IDX_W +: IDX_W])) begin
          data_rd_d[p*DATA_WIDTH +: DATA_WIDTH] = rd_src_data[index_rd[p*IDX_W +: IDX_W]];
          rd_hit_d[p] = rd_src_valid[index_rd[p*IDX_W +: IDX_W]];
        end else begin
          data_rd_d[p*DATA_WIDTH +: DATA_WIDTH] = '0;
          rd_hit_d[p] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < TABLE_SIZE; e++) begin
        mem_q[e] <= '0;
      end
      valid_q       <= '0;
      data_rd_q     <= '0;
      rd_valid_q    <= '0;
      rd_hit_q      <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      for (int e = 0; e < TABLE_SIZE; e++) begin
        mem_q[e] <= mem_d[e];
      end
      valid_q       <= valid_d;
      data_rd_q     <= data_rd_d;
      rd_valid_q    <= rd_valid_d;
      rd_hit_q      <= rd_hit_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign data_rd     = data_rd_q;
  assign rd_valid    = rd_valid_q;
  assign rd_hit      = rd_hit_q;
  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_multi_port_table.sv
// Scoreboard bench: a 32-entry bypassing table and a 20-entry non-bypassing table
// share one stimulus stream; each has its own behavioural model.
module tb_multi_port_table;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wr_en;
  logic [9:0]  index_wr;
  logic [15:0] data_wr;
  logic [1:0]  rd_en;
  logic [9:0]  index_rd;
  logic        clr_start;

  logic [15:0] data_rd_a, data_rd_b;
  logic [1:0]  rd_valid_a, rd_valid_b, rd_hit_a, rd_hit_b;
  logic        wr_conflict_a, wr_conflict_b, clr_busy_a, clr_busy_b;

  always #5 clk = ~clk;

  multi_port_table #(
    .TABLE_SIZE(32), .DATA_WIDTH(8), .WR_PORTS(2), .RD_PORTS(2), .RD_BYPASS(1)
  ) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .index_wr(index_wr), .data_wr(data_wr),
    .rd_en(rd_en), .index_rd(index_rd), .data_rd(data_rd_a), .rd_valid(rd_valid_a),
    .rd_hit(rd_hit_a), .wr_conflict(wr_conflict_a), .clr_start(clr_start),
    .clr_busy(clr_busy_a)
  );

  multi_port_table #(
    .TABLE_SIZE(20), .DATA_WIDTH(8), .WR_PORTS(2), .RD_PORTS(2), .RD_BYPASS(0)
  ) u_dut_nb (
    .clk(clk), .rst(rst), .wr_en(wr_en), .index_wr(index_wr), .data_wr(data_wr),
    .rd_en(rd_en), .index_rd(index_rd), .data_rd(data_rd_b), .rd_valid(rd_valid_b),
    .rd_hit(rd_hit_b), .wr_conflict(wr_conflict_b), .clr_start(clr_start),
    .clr_busy(clr_busy_b)
  );

  typedef struct {
    int         dut;
    int         port;
    logic [7:0] data;
    logic       hit;
  } rd_exp_t;

  rd_exp_t    exp_q[$];
  int         m_size[2] = '{32, 20};
  int         m_byp[2]  = '{1, 0};
  logic [7:0] m_mem[2][32];
  logic       m_valid[2][32];
  logic       m_busy[2];
  int         m_ptr[2];
  logic [7:0] m_last_data[2][2];
  logic       m_last_hit[2][2];
  logic       exp_rdv[2][2];
  logic       exp_conf[2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int e = 0; e < 32; e++) begin
        m_mem[d][e]   = 8'h00;
        m_valid[d][e] = 1'b0;
      end
      m_busy[d]   = 1'b0;
      m_ptr[d]    = 0;
      exp_conf[d] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        m_last_data[d][p] = 8'h00;
        m_last_hit[d][p]  = 1'b0;
        exp_rdv[d][p]     = 1'b0;
      end
    end
    exp_q.delete();
  endtask

  task automatic check_outputs(input string what);
    rd_exp_t     e;
    logic [15:0] drd;
    logic [1:0]  rdv, rhit;
    logic        busy, conf;
    for (int d = 0; d < 2; d++) begin
      drd  = (d == 0) ? data_rd_a : data_rd_b;
      rdv  = (d == 0) ? rd_valid_a : rd_valid_b;
      rhit = (d == 0) ? rd_hit_a : rd_hit_b;
      busy = (d == 0) ? clr_busy_a : clr_busy_b;
      conf = (d == 0) ? wr_conflict_a : wr_conflict_b;
      check_eq($sformatf("%s d%0d clr_busy", what, d), 32'(busy), 32'(m_busy[d]));
      check_eq($sformatf("%s d%0d wr_conflict", what, d), 32'(conf), 32'(exp_conf[d]));
      for (int p = 0; p < 2; p++) begin
        check_eq($sformatf("%s d%0d p%0d rd_valid", what, d, p), 32'(rdv[p]), 32'(exp_rdv[d][p]));
        if (exp_rdv[d][p] && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq($sformatf("%s d%0d p%0d data_rd", what, d, p), 32'(drd[p*8 +: 8]), 32'(e.data));
          check_eq($sformatf("%s d%0d p%0d rd_hit", what, d, p), 32'(rhit[p]), 32'(e.hit));
        end else begin
          check_eq($sformatf("%s d%0d p%0d data_hold", what, d, p), 32'(drd[p*8 +: 8]), 32'(m_last_data[d][p]));
          check_eq($sformatf("%s d%0d p%0d hit_hold", what, d, p), 32'(rhit[p]), 32'(m_last_hit[d][p]));
        end
      end
    end
  endtask

  task automatic do_reset(input string what);
    rst       = 1'b1;
    wr_en     = '0;
    rd_en     = '0;
    index_wr  = '0;
    index_rd  = '0;
    data_wr   = '0;
    clr_start = 1'b0;
    model_reset();
    $display("[TB] %s: reset", what);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs(what);
  endtask

  task automatic do_cycle(input string what, input logic [1:0] we, input int wi0, input int wi1,
                          input logic [7:0] wd0, input logic [7:0] wd1, input logic [1:0] re,
                          input int ri0, input int ri1, input logic cs);
    int         wi[2];
    int         ri[2];
    logic [7:0] wd[2];
    logic [7:0] nm[32];
    logic       nv[32];
    rd_exp_t    e;
    wi = '{wi0, wi1};
    ri = '{ri0, ri1};
    wd = '{wd0, wd1};
    wr_en     = we;
    index_wr  = {5'(wi1), 5'(wi0)};
    data_wr   = {wd1, wd0};
    rd_en     = re;
    index_rd  = {5'(ri1), 5'(ri0)};
    clr_start = cs;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 32; k++) begin
        nm[k] = m_mem[d][k];
        nv[k] = m_valid[d][k];
      end
      if (m_busy[d]) nv[m_ptr[d]] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (we[p] && wi[p] < m_size[d]) begin
          nm[wi[p]] = wd[p];
          nv[wi[p]] = 1'b1;
        end
      end
      exp_conf[d] = (we == 2'b11) && (wi0 == wi1) && (wi0 < m_size[d]);
      for (int p = 0; p < 2; p++) begin
        exp_rdv[d][p] = re[p];
        if (re[p]) begin
          e.dut  = d;
          e.port = p;
          if (ri[p] >= m_size[d]) begin
            e.data = 8'h00;
            e.hit  = 1'b0;
          end else if (m_byp[d] != 0) begin
            e.data = nm[ri[p]];
            e.hit  = nv[ri[p]];
          end else begin
            e.data = m_mem[d][ri[p]];
            e.hit  = m_valid[d][ri[p]];
          end
          exp_q.push_back(e);
          m_last_data[d][p] = e.data;
          m_last_hit[d][p]  = e.hit;
        end
      end
      for (int k = 0; k < 32; k++) begin
        m_mem[d][k]   = nm[k];
        m_valid[d][k] = nv[k];
      end
      if (m_busy[d]) begin
        if (m_ptr[d] == m_size[d] - 1) begin
          m_busy[d] = 1'b0;
          m_ptr[d]  = 0;
        end else begin
          m_ptr[d]++;
        end
      end else if (cs) begin
        m_busy[d] = 1'b1;
        m_ptr[d]  = 0;
      end
    end
    $display("[TB] %s: we=%b wi=%0d/%0d wd=%h/%h re=%b ri=%0d/%0d clr=%b",
             what, we, wi0, wi1, wd0, wd1, re, ri0, ri1, cs);
    @(posedge clk);
    #1;
    check_outputs(what);
  endtask

  initial begin
    do_reset("reset");

    for (int i = 0; i < 32; i++)
      do_cycle("rd_after_reset", 2'b00, 0, 0, 8'h00, 8'h00, 2'b11, i, 31 - i, 1'b0);

    do_cycle("wr_basic", 2'b11, 3, 7, 8'hA5, 8'h5A, 2'b00, 0, 0, 1'b0);
    do_cycle("rd_basic", 2'b00, 0, 0, 8'h00, 8'h00, 2'b11, 3, 7, 1'b0);

    do_cycle("wr_collide", 2'b11, 5, 5, 8'h11, 8'h22, 2'b00, 0, 0, 1'b0);
    do_cycle("rd_collide", 2'b00, 0, 0, 8'h00, 8'h00, 2'b01, 5, 0, 1'b0);
    do_cycle("idle_hold", 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 0, 0, 1'b0);

    do_cycle("wr_byp_old", 2'b01, 9, 0, 8'h01, 8'h00, 2'b00, 0, 0, 1'b0);
    do_cycle("byp", 2'b01, 9, 0, 8'h02, 8'h00, 2'b01, 9, 0, 1'b0);

    do_cycle("wr_oor", 2'b01, 25, 0, 8'h3C, 8'h00, 2'b00, 0, 0, 1'b0);
    do_cycle("rd_oor", 2'b00, 0, 0, 8'h00, 8'h00, 2'b11, 25, 19, 1'b0);

    for (int i = 0; i < 16; i++)
      do_cycle("fill", 2'b11, 2 * i, 2 * i + 1, 8'(i * 14 + 3), 8'(i * 14 + 10), 2'b00, 0, 0, 1'b0);
    do_cycle("clr_start", 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 0, 0, 1'b1);
    for (int k = 1; k <= 32; k++) begin
      if (k == 10)
        do_cycle("sweep_wr", 2'b11, 9, 31, 8'h99, 8'h77, 2'b11, 9, 31, 1'b0);
      else
        do_cycle("sweep", 2'b00, 0, 0, 8'h00, 8'h00, 2'b11, k - 1,
                 int'($urandom_range(0, 31)), (k == 15));
    end
    for (int i = 0; i < 32; i++)
      do_cycle("rd_after_sweep", 2'b00, 0, 0, 8'h00, 8'h00, 2'b11, i, i, 1'b0);

    for (int i = 0; i < 16; i++)
      do_cycle("refill", 2'b11, 2 * i, 2 * i + 1, 8'(i + 8'h40), 8'(i + 8'h80), 2'b00, 0, 0, 1'b0);
    do_cycle("clr_start2", 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 0, 0, 1'b1);
    for (int k = 1; k <= 4; k++)
      do_cycle("sweep2", 2'b00, 0, 0, 8'h00, 8'h00, 2'b10, 0, k + 10, 1'b0);
    do_reset("reset_mid_sweep");
    for (int i = 0; i < 32; i++)
      do_cycle("rd_after_abort", 2'b00, 0, 0, 8'h00, 8'h00, 2'b11, i, 31 - i, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
